// File: rtl/boid_pkg.sv
// Shared constants and types for the boid update pipeline.
package boid_pkg;

  localparam int FRAC_BITS = 16;

  // Stored field widths in the boid state memory
  localparam int X_W   = 28;
  localparam int Y_W   = 27;
  localparam int V_W   = 21;
  localparam int ACC_W = 32;

  // wb_en bit positions
  localparam int WB_GLOBAL = 0;
  localparam int WB_X      = 1;
  localparam int WB_Y      = 2;
  localparam int WB_VX     = 3;
  localparam int WB_VY     = 4;
  localparam int WB_VX_ACC = 5;
  localparam int WB_VY_ACC = 6;

  localparam logic [6:0] WB_ALL = 7'h7F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_VEL,
    ST_POS,
    ST_WB
  } state_e;

endpackage

// File: rtl/boid_axis_update.sv
// Single-axis combinational step: velocity (add, steer, clamp) and position.
// BOID_INTEG_WRAP_EN: drop edge steering and wrap the position toroidally.
module boid_axis_update
  import boid_pkg::*;
#(
  parameter int DIM         = 640,
  parameter int MARGIN      = 100,
  parameter int TURN_FACTOR = 13107,
  parameter int MAX_SPEED   = 393216
) (
  input  logic [31:0] pos_i,   // current position
  input  logic [31:0] vel_i,   // current velocity
  input  logic [31:0] acc_i,   // accumulated velocity delta
  input  logic [31:0] vnew_i,  // registered updated velocity
  output logic [31:0] vel_o,   // updated velocity
  output logic [31:0] pos_o    // updated position
);

  // 34 bits leaves headroom for the 33-bit sum plus one steer step
  localparam logic signed [33:0] TURN = 34'(TURN_FACTOR);
  localparam logic signed [33:0] VMAX = 34'(MAX_SPEED);
`ifdef BOID_INTEG_WRAP_EN
  localparam logic signed [31:0] SPAN = 32'(DIM) <<< FRAC_BITS;
`endif

  logic signed [33:0] sum;
  logic signed [33:0] steer;
  logic signed [31:0] pos_int;
  logic signed [31:0] p_new;

  // Velocity: add accumulator, steer off screen edges, clamp per axis
  always_comb begin
    sum     = $signed({{2{vel_i[31]}}, vel_i}) + $signed({{2{acc_i[31]}}, acc_i});
    pos_int = $signed(pos_i) >>> FRAC_BITS;
    steer   = sum;
`ifndef BOID_INTEG_WRAP_EN
    if (pos_int < MARGIN)       steer = steer + TURN;
    if (pos_int > DIM - MARGIN) steer = steer - TURN;
`endif
    if (steer > VMAX)       vel_o = VMAX[31:0];
    else if (steer < -VMAX) vel_o = 32'(-VMAX);
    else                    vel_o = steer[31:0];
  end

  // Position: plain 32-bit integrate, optionally folded back onto the screen
  always_comb begin
    p_new = $signed(pos_i) + $signed(vnew_i);
`ifdef BOID_INTEG_WRAP_EN
    if (p_new < 0)          p_new = p_new + SPAN;
    else if (p_new >= SPAN) p_new = p_new - SPAN;
`endif
    pos_o = p_new;
  end

endmodule

// File: rtl/boid_integrator.sv
// Per-frame boid update controller: read, velocity, position, write-back
// for each boid in turn, then a one-cycle done pulse.
// BOID_INTEG_WRAP_EN: toroidal position wrap instead of edge steering.
module boid_integrator
  import boid_pkg::*;
#(
  parameter int NUM_BOIDS   = 2,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int MARGIN      = 100,
  parameter int TURN_FACTOR = 13107,
  parameter int MAX_SPEED   = 393216
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_BOIDS):0]   which_boid,
  output logic [6:0]                   wb_en,
  input  logic [31:0]                  x_rd,
  input  logic [31:0]                  y_rd,
  input  logic [31:0]                  vx_rd,
  input  logic [31:0]                  vy_rd,
  input  logic [31:0]                  vx_acc_rd,
  input  logic [31:0]                  vy_acc_rd,
  output logic [31:0]                  x_wr,
  output logic [31:0]                  y_wr,
  output logic [31:0]                  vx_wr,
  output logic [31:0]                  vy_wr,
  output logic [31:0]                  vx_acc_wr,
  output logic [31:0]                  vy_acc_wr
);

  localparam int IW = $clog2(NUM_BOIDS) + 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_BOIDS - 1);

  state_e        state_q;
  logic          busy_q, done_q;
  logic [IW-1:0] idx_q;
  logic [6:0]    wb_en_q;
  logic [31:0]   x_rq, y_rq, vx_rq, vy_rq, vxa_rq, vya_rq;
  logic [31:0]   vx_q, vy_q, x_q, y_q;
  logic [31:0]   vx_d, vy_d, x_d, y_d;

  boid_axis_update #(
    .DIM(SCREEN_W), .MARGIN(MARGIN), .TURN_FACTOR(TURN_FACTOR), .MAX_SPEED(MAX_SPEED)
  ) u_axis_x (
    .pos_i(x_rq), .vel_i(vx_rq), .acc_i(vxa_rq), .vnew_i(vx_q),
    .vel_o(vx_d), .pos_o(x_d)
  );

  boid_axis_update #(
    .DIM(SCREEN_H), .MARGIN(MARGIN), .TURN_FACTOR(TURN_FACTOR), .MAX_SPEED(MAX_SPEED)
  ) u_axis_y (
    .pos_i(y_rq), .vel_i(vy_rq), .acc_i(vya_rq), .vnew_i(vy_q),
    .vel_o(vy_d), .pos_o(y_d)
  );

  // Sequencer plus all datapath registers; every output is registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      wb_en_q <= '0;
      x_rq    <= '0; y_rq   <= '0; vx_rq <= '0; vy_rq <= '0;
      vxa_rq  <= '0; vya_rq <= '0;
      vx_q    <= '0; vy_q   <= '0; x_q   <= '0; y_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= '0;
      unique case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_READ;
          busy_q  <= 1'b1;
          idx_q   <= '0;
        end
        ST_READ: begin
          // memory read is combinational on which_boid, so capture now
          x_rq   <= x_rd;      y_rq   <= y_rd;
          vx_rq  <= vx_rd;     vy_rq  <= vy_rd;
          vxa_rq <= vx_acc_rd; vya_rq <= vy_acc_rd;
          state_q <= ST_VEL;
        end
        ST_VEL: begin
          vx_q    <= vx_d;
          vy_q    <= vy_d;
          state_q <= ST_POS;
        end
        ST_POS: begin
          x_q     <= x_d;
          y_q     <= y_d;
          wb_en_q <= WB_ALL;
          state_q <= ST_WB;
        end
        ST_WB: begin
          if (idx_q < LAST) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_READ;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign which_boid = idx_q;
  assign wb_en      = wb_en_q;
  assign x_wr       = x_q;
  assign y_wr       = y_q;
  assign vx_wr      = vx_q;
  assign vy_wr      = vy_q;
  assign vx_acc_wr  = '0;
  assign vy_acc_wr  = '0;

endmodule

// File: tb/tb_boid_integrator.sv
// Directed bench for boid_integrator with a small boid memory model.
module tb_boid_integrator;

  localparam int F = 65536;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  which_boid;
  logic [6:0]  wb_en;
  logic [31:0] x_rd, y_rd, vx_rd, vy_rd, vx_acc_rd, vy_acc_rd;
  logic [31:0] x_wr, y_wr, vx_wr, vy_wr, vx_acc_wr, vy_acc_wr;

  logic [31:0] mem_x [0:3], mem_y [0:3], mem_vx [0:3], mem_vy [0:3];
  logic [31:0] mem_vxa [0:3], mem_vya [0:3];

  logic        ld_en = 1'b0;
  logic [1:0]  ld_idx = '0;
  logic [31:0] ld_x, ld_y, ld_vx, ld_vy, ld_vxa, ld_vya;

  int n_chk = 0;
  int n_err = 0;

  boid_integrator #(.NUM_BOIDS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .which_boid(which_boid), .wb_en(wb_en),
    .x_rd(x_rd), .y_rd(y_rd), .vx_rd(vx_rd), .vy_rd(vy_rd),
    .vx_acc_rd(vx_acc_rd), .vy_acc_rd(vy_acc_rd),
    .x_wr(x_wr), .y_wr(y_wr), .vx_wr(vx_wr), .vy_wr(vy_wr),
    .vx_acc_wr(vx_acc_wr), .vy_acc_wr(vy_acc_wr)
  );

  always #5 clk = ~clk;

  assign x_rd      = mem_x[which_boid];
  assign y_rd      = mem_y[which_boid];
  assign vx_rd     = mem_vx[which_boid];
  assign vy_rd     = mem_vy[which_boid];
  assign vx_acc_rd = mem_vxa[which_boid];
  assign vy_acc_rd = mem_vya[which_boid];

  // memory model: bench preload port, else DUT write-back port
  always @(posedge clk) begin
    if (ld_en) begin
      mem_x[ld_idx] <= ld_x;   mem_y[ld_idx] <= ld_y;
      mem_vx[ld_idx] <= ld_vx; mem_vy[ld_idx] <= ld_vy;
      mem_vxa[ld_idx] <= ld_vxa; mem_vya[ld_idx] <= ld_vya;
    end else if (wb_en[0]) begin
      if (wb_en[1]) mem_x[which_boid]   <= x_wr;
      if (wb_en[2]) mem_y[which_boid]   <= y_wr;
      if (wb_en[3]) mem_vx[which_boid]  <= vx_wr;
      if (wb_en[4]) mem_vy[which_boid]  <= vy_wr;
      if (wb_en[5]) mem_vxa[which_boid] <= vx_acc_wr;
      if (wb_en[6]) mem_vya[which_boid] <= vy_acc_wr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag,
               $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int x, input int y, input int vx,
                      input int vy, input int vxa, input int vya);
    ld_idx = 2'(idx);
    ld_x = x; ld_y = y; ld_vx = vx; ld_vy = vy; ld_vxa = vxa; ld_vya = vya;
    ld_en = 1'b1;
    step();
    ld_en = 1'b0;
  endtask

  // one start pulse, then wait (bounded) for done
  task automatic run_pass(input string tag);
    bit seen;
    seen  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
  endtask

  initial begin
    ld_x = '0; ld_y = '0; ld_vx = '0; ld_vy = '0; ld_vxa = '0; ld_vya = '0;
    for (int i = 0; i < 4; i++) begin
      mem_x[i] = '0; mem_y[i] = '0; mem_vx[i] = '0; mem_vy[i] = '0;
      mem_vxa[i] = '0; mem_vya[i] = '0;
    end
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_which", 32'(which_boid), 0);
    check("rst_x_wr", x_wr, 0);
    reset = 1'b1;
    step();

    // ---- nominal + clamp pass with exact cycle timing ----
    load(0, 120*F, 200*F, 5*F, 0, 0, 0);
    load(1, 300*F, 300*F, 5*F, -5*F, 3*F, -3*F);
    start = 1'b1;                       // cycle 0
    for (int c = 1; c <= 10; c++) begin
      step();
      start = (c == 3);                 // ignored: FSM is busy
      check($sformatf("t_busy_c%0d", c), 32'(busy), 32'((c >= 1 && c <= 8) ? 1 : 0));
      check($sformatf("t_wb_en_c%0d", c), 32'(wb_en), 32'((c == 4 || c == 8) ? 7'h7F : 7'h00));
      check($sformatf("t_done_c%0d", c), 32'(done), 32'((c == 9) ? 1 : 0));
      if (c == 4) begin
        check("nom_which", 32'(which_boid), 0);
        check("nom_vx_wr", vx_wr, 5*F);
        check("nom_x_wr", x_wr, 125*F);
        check("nom_y_wr", y_wr, 200*F);
        check("nom_vxacc_wr", vx_acc_wr, 0);
      end
      if (c == 8) begin
        check("clamp_which", 32'(which_boid), 1);
        check("clamp_vx_pos", vx_wr, 393216);
        check("clamp_vy_neg", vy_wr, -393216);
        check("clamp_x_wr", x_wr, 306*F);
        check("clamp_y_wr", y_wr, 294*F);
      end
    end
    check("mem0_x", mem_x[0], 125*F);
    check("mem1_vxa_cleared", mem_vxa[1], 0);
    check("mem1_vya_cleared", mem_vya[1], 0);

`ifdef BOID_INTEG_WRAP_EN
    // ---- toroidal wrap ----
    load(0, 638*F, 200*F, 5*F, 0, 0, 0);
    load(1, 1*F, 200*F, -3*F, 0, 0, 0);
    run_pass("wrap");
    check("wrap_hi_x", mem_x[0], 3*F);
    check("wrap_lo_x", mem_x[1], 638*F);
`else
    // ---- edge steering ----
    load(0, 50*F, 200*F, 0, 0, 0, 0);
    load(1, 600*F, 440*F, 0, 0, 0, 0);
    run_pass("margin");
    check("left_vx", mem_vx[0], 13107);
    check("left_x", mem_x[0], 50*F + 13107);
    check("right_vx", mem_vx[1], -13107);
    check("right_x", mem_x[1], 600*F - 13107);
    check("bottom_vy", mem_vy[1], -13107);
    check("bottom_y", mem_y[1], 440*F - 13107);
`endif

    // ---- reset in VEL of boid1 ----
    load(0, 200*F, 200*F, 1*F, 0, 0, 0);
    load(1, 300*F, 250*F, 2*F, 0, 1*F, 0);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    reset = 1'b0;                       // cycle 6: boid1 in VEL
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_which", 32'(which_boid), 0);
    check("arst_wb_en", 32'(wb_en), 0);
    check("arst_vx_wr", vx_wr, 0);
    check("arst_x_wr", x_wr, 0);
    #2;
    reset = 1'b1;
    step();
    step();
    check("arst_mem1_x", mem_x[1], 300*F);
    check("arst_mem1_vxa", mem_vxa[1], 1*F);
    check("arst_mem0_x", mem_x[0], 201*F);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_which", 32'(which_boid), 0);
    check("restart_busy", 32'(busy), 1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        if (done) seen = 1'b1;
      end
      check("restart_done_seen", 32'(seen), 1);
    end
    step();
    check("restart_mem0_x", mem_x[0], 202*F);
    check("restart_mem1_x", mem_x[1], 303*F);
    check("restart_mem1_vx", mem_vx[1], 3*F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
